// File: rtl/cipher_bonus.sv
// cipher_bonus: multi-cycle repeating-key XOR stream cipher.
// Processes an N-bit word one byte per clock, byte 0 (bits [7:0]) first.
// XOR is self-inverse, so the same block encrypts and decrypts.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   request; accepted only in IDLE or DONE
//   key        in   8-bit key, captured when start is accepted
//   plaintext  in   N-bit data, captured when start is accepted
//   done       out  high while the result is valid (DONE state)
//   ciphertext out  N-bit registered result
//
// Configuration macro:
//   CIPHER_KEY_ROTATE_EN  when defined, the captured key rotates left by one
//                         after every byte (byte i uses key rotl i).
module cipher_bonus #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   key,
  input  logic [N-1:0] plaintext,
  output logic         done,
  output logic [N-1:0] ciphertext
);

  localparam int unsigned NB   = N / 8;
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

  if ((N % 8 != 0) || (N < 8)) begin : g_bad_n
    $error("cipher_bonus: N must be a multiple of 8 and >= 8");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [N-1:0]    pt_q, pt_d;
  logic [N-1:0]    ct_q, ct_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          key_d   = key;
          pt_d    = plaintext;
          ct_d    = '0;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Constant-indexed byte lanes keep the select simple for synthesis.
        for (int unsigned i = 0; i < NB; i++) begin
          if (idx_q == IdxW'(i)) begin
            ct_d[8*i +: 8] = pt_q[8*i +: 8] ^ key_q;
          end
        end
`ifdef CIPHER_KEY_ROTATE_EN
        key_d = {key_q[6:0], key_q[7]};
`else
        key_d = key_q;
`endif
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      idx_q   <= idx_d;
    end
  end

  assign done       = (state_q == StDone);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_cipher_bonus.sv
module tb_cipher_bonus;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start24;
  logic [7:0]  key16, key24;
  logic [15:0] pt16, ct16;
  logic [23:0] pt24, ct24;
  logic        done16, done24;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp16_q[$];
  logic [23:0] exp24_q[$];

  always #5 clk = ~clk;

  cipher_bonus #(.N(16)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .start      (start16),
    .key        (key16),
    .plaintext  (pt16),
    .done       (done16),
    .ciphertext (ct16)
  );

  cipher_bonus #(.N(24)) u_dut24 (
    .clk        (clk),
    .rst        (rst),
    .start      (start24),
    .key        (key24),
    .plaintext  (pt24),
    .done       (done24),
    .ciphertext (ct24)
  );

  // Reference: byte i = pt byte i XOR key (rotated left by i when rotation is enabled).
  function automatic logic [23:0] model(input logic [7:0] k, input logic [23:0] p, input int nb);
    logic [23:0] r;
    logic [7:0]  kk;
    r  = '0;
    kk = k;
    for (int i = 0; i < nb; i++) begin
      r[8*i +: 8] = p[8*i +: 8] ^ kk;
`ifdef CIPHER_KEY_ROTATE_EN
      kk = {kk[6:0], kk[7]};
`endif
    end
    return r;
  endfunction

  // Published vectors assume no rotation; under rotation fall back to the reference.
  function automatic logic [23:0] pick(input logic [23:0] lit, input logic [7:0] k,
                                       input logic [23:0] p, input int nb);
`ifdef CIPHER_KEY_ROTATE_EN
    return model(k, p, nb);
`else
    return lit;
`endif
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [7:0] k, input logic [15:0] p, input logic [23:0] exp,
                       input string tag);
    int lat;
    logic [23:0] e;
    key16   = k;
    pt16    = p;
    start16 = 1'b1;
    exp16_q.push_back(exp);
    tick();
    start16 = 1'b0;
    key16   = 8'($urandom);
    pt16    = 16'($urandom);
    check({tag, " done_low_after_start"}, {23'd0, done16}, 24'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done16 && lat < 10);
    check({tag, " latency"}, 24'(lat), 24'd2);
    e = exp16_q.pop_front();
    check({tag, " ciphertext"}, {8'd0, ct16}, e);
  endtask

  task automatic run24(input logic [7:0] k, input logic [23:0] p, input logic [23:0] exp,
                       input string tag);
    int lat;
    logic [23:0] e;
    key24   = k;
    pt24    = p;
    start24 = 1'b1;
    exp24_q.push_back(exp);
    tick();
    start24 = 1'b0;
    key24   = 8'($urandom);
    pt24    = 24'($urandom);
    check({tag, " done_low_after_start"}, {23'd0, done24}, 24'd0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done24 && lat < 10);
    check({tag, " latency"}, 24'(lat), 24'd3);
    e = exp24_q.pop_front();
    check({tag, " ciphertext"}, ct24, e);
  endtask

  initial begin
    logic [7:0]  rk;
    logic [15:0] rp;
    rst = 1'b1; start16 = 1'b0; start24 = 1'b0;
    key16 = '0; pt16 = '0; key24 = '0; pt24 = '0;

    // Reset state
    #2;
    check("reset done16", {23'd0, done16}, 24'd0);
    check("reset ct16", {8'd0, ct16}, 24'd0);
    check("reset done24", {23'd0, done24}, 24'd0);
    check("reset ct24", ct24, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("idle done16", {23'd0, done16}, 24'd0);
    check("idle ct16", {8'd0, ct16}, 24'd0);

    // Basic run
    run16(8'hAA, 16'hCCF0, pick(24'h00665A, 8'hAA, 24'h00CCF0, 2), "basic");

    // Back-to-back, no idle cycle
    run16(8'hF0, 16'h3C3C, pick(24'h00CCCC, 8'hF0, 24'h003C3C, 2), "b2b1");
    run16(8'h33, 16'h5555, pick(24'h006666, 8'h33, 24'h005555, 2), "b2b2");

    // Start pulsed while busy must be ignored
    key16 = 8'hAA; pt16 = 16'hCCF0; start16 = 1'b1;
    exp16_q.push_back(pick(24'h00665A, 8'hAA, 24'h00CCF0, 2));
    tick();
    key16 = 8'h00; pt16 = 16'hFFFF;
    tick();
    start16 = 1'b0;
    tick();
    check("busy_ignore done", {23'd0, done16}, 24'd1);
    check("busy_ignore ct", {8'd0, ct16}, exp16_q.pop_front());
    repeat (2) tick();
    check("done_hold done", {23'd0, done16}, 24'd1);
    check("done_hold ct", {8'd0, ct16}, pick(24'h00665A, 8'hAA, 24'h00CCF0, 2));

    // Start held high: DONE lasts one cycle, then restarts immediately
    key16 = 8'hF0; pt16 = 16'h3C3C; start16 = 1'b1;
    repeat (3) tick();
    check("held done", {23'd0, done16}, 24'd1);
    check("held ct", {8'd0, ct16}, pick(24'h00CCCC, 8'hF0, 24'h003C3C, 2));
    tick();
    check("held restart done", {23'd0, done16}, 24'd0);
    check("held restart ct", {8'd0, ct16}, 24'd0);
    start16 = 1'b0;
    repeat (2) tick();
    check("held second done", {23'd0, done16}, 24'd1);

    // Reset mid-run
    key16 = 8'hAA; pt16 = 16'hCCF0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    check("partial byte0", {8'd0, ct16}, {8'd0, 8'h00, 8'h5A});
    rst = 1'b1;
    #1;
    check("midrst done", {23'd0, done16}, 24'd0);
    check("midrst ct", {8'd0, ct16}, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst idle done", {23'd0, done16}, 24'd0);
    check("midrst idle ct", {8'd0, ct16}, 24'd0);

    // N=24
    run24(8'hCC, 24'hAAF0F0, pick(24'h663C3C, 8'hCC, 24'hAAF0F0, 3), "n24a");
    run24(8'hFF, 24'hF0F0F0, pick(24'h0F0F0F, 8'hFF, 24'hF0F0F0, 3), "n24b");

    // A few random runs against the reference
    for (int i = 0; i < 4; i++) begin
      rk = 8'($urandom);
      rp = 16'($urandom);
      run16(rk, rp, model(rk, {8'd0, rp}, 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
